// File: rtl/data_mem_responder_if.sv
// Memory-stage bus between the datapath and data_mem_responder.
// The signal names follow the original responder port list.
interface data_mem_responder_if;
  logic        i_MemRead;
  logic        i_MemWrite;
  logic [31:0] i_address;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        o_ready;
  logic        o_busy;
  logic        o_err;

  modport master (
    output i_MemRead, i_MemWrite, i_address, i_data,
    input  o_data, o_ready, o_busy, o_err
  );

  modport slave (
    input  i_MemRead, i_MemWrite, i_address, i_data,
    output o_data, o_ready, o_busy, o_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with programmable wait states and a one-cycle ready pulse.
// Optional macro DMEM_ALIGN_CHECK_EN turns misaligned requests into error completions.
module data_mem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 i_clk,
  input logic                 i_rst,
  data_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              err_q, err_d;
  logic [31:0]       o_data_q, o_data_d;
  logic              o_ready_q, o_ready_d;
  logic              o_err_q, o_err_d;

  logic [31:0] mem [2**ADDR_W];
  logic        mem_we;
  logic        req, both, misal, enter_resp;
  logic        unused_addr_bits;

  assign req  = bus.i_MemRead | bus.i_MemWrite;
  assign both = bus.i_MemRead & bus.i_MemWrite;
`ifdef DMEM_ALIGN_CHECK_EN
  assign misal = (bus.i_address[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif
  assign unused_addr_bits = ^{bus.i_address[31:ADDR_W+2], bus.i_address[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    err_d      = err_q;
    o_data_d   = o_data_q;
    o_ready_d  = 1'b0;
    o_err_d    = 1'b0;
    enter_resp = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = bus.i_address[ADDR_W+1:2];
          wdata_d = bus.i_data;
          wr_d    = bus.i_MemWrite & ~misal;
          rd_d    = bus.i_MemRead & ~bus.i_MemWrite & ~misal;
          err_d   = both | misal;
          cnt_d   = '0;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d    = S_RESP;
          cnt_d      = '0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        mem_we  = wr_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered on the edge entering RESP so read data is visible in
    // the RESP cycle; the _d copies cover the zero-wait path where nothing is latched yet.
    if (enter_resp) begin
      o_ready_d = 1'b1;
      o_err_d   = err_d;
      if (rd_d) o_data_d = mem[idx_d];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      err_q     <= 1'b0;
      o_data_q  <= '0;
      o_ready_q <= 1'b0;
      o_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      o_data_q  <= o_data_d;
      o_ready_q <= o_ready_d;
      o_err_q   <= o_err_d;
    end
  end

  // Storage keeps its contents across reset; a reset edge only blocks a pending commit.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_rst) mem[idx_q] <= wdata_q;
  end

  assign bus.o_data  = o_data_q;
  assign bus.o_ready = o_ready_q;
  assign bus.o_err   = o_err_q;
  assign bus.o_busy  = !i_rst && (((state_q == S_IDLE) && req) || (state_q == S_WAIT));
endmodule

// File: tb/tb_data_mem_responder.sv
// Two responders (2 and 0 wait states) share one stimulus stream and are checked
// every cycle against a timestamp-based transaction model, plus literal pins.
module tb_data_mem_responder;
  localparam int NI = 2;
  localparam int W0 = 2;
  localparam int W1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd, wr;
  logic [31:0] addr, wdata;

  data_mem_responder_if bus0();
  data_mem_responder_if bus1();

  assign bus0.i_MemRead  = rd;
  assign bus0.i_MemWrite = wr;
  assign bus0.i_address  = addr;
  assign bus0.i_data     = wdata;
  assign bus1.i_MemRead  = rd;
  assign bus1.i_MemWrite = wr;
  assign bus1.i_address  = addr;
  assign bus1.i_data     = wdata;

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp_v);
    end
  endtask

  function automatic int wc(int i);
    return (i == 0) ? W0 : W1;
  endfunction

  // {busy, ready, err, data}
  function automatic logic [34:0] outs(int i);
    if (i == 0) return {bus0.o_busy, bus0.o_ready, bus0.o_err, bus0.o_data};
    return {bus1.o_busy, bus1.o_ready, bus1.o_err, bus1.o_data};
  endfunction

  // Transaction model: a request accepted at edge e completes in the cycle ending
  // at edge e+1+W; the write lands at that edge, read data shows during that cycle.
  longint      cyc = 0;
  bit          pend   [NI];
  longint      resp_k [NI];
  bit          p_wr   [NI];
  bit          p_rd   [NI];
  bit          p_err  [NI];
  int          p_idx  [NI];
  logic [31:0] p_dat  [NI];
  logic [31:0] exp_data [NI];
  logic [31:0] ref_mem [NI][256];
  bit          mis;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        pend[i]     = 1'b0;
        exp_data[i] = '0;
      end else if (pend[i]) begin
        if (cyc == resp_k[i]) begin
          if (p_wr[i]) ref_mem[i][p_idx[i]] = p_dat[i];
          pend[i] = 1'b0;
        end
      end else if (rd || wr) begin
        mis = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (addr % 4) != 0;
`endif
        pend[i]   = 1'b1;
        resp_k[i] = cyc + 1 + wc(i);
        p_idx[i]  = int'((addr >> 2) % 256);
        p_dat[i]  = wdata;
        p_err[i]  = (rd && wr) || mis;
        p_wr[i]   = wr && !mis;
        p_rd[i]   = rd && !wr && !mis;
      end
      if (!rst && pend[i] && resp_k[i] == cyc + 1 && p_rd[i]) exp_data[i] = ref_mem[i][p_idx[i]];
    end
  end

  logic [34:0] co;
  bit          e_rdy, e_busy;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        e_rdy  = pend[i] && (resp_k[i] == cyc + 1);
        e_busy = !rst && ((!pend[i] && (rd || wr)) || (pend[i] && resp_k[i] > cyc + 1));
        co     = outs(i);
        chk($sformatf("busy%0d@%0d", i, cyc), {31'd0, co[34]}, {31'd0, e_busy});
        chk($sformatf("ready%0d@%0d", i, cyc), {31'd0, co[33]}, {31'd0, e_rdy});
        chk($sformatf("err%0d@%0d", i, cyc), {31'd0, co[32]}, {31'd0, e_rdy && p_err[i]});
        chk($sformatf("data%0d@%0d", i, cyc), co[31:0], exp_data[i]);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  int lat  [NI];
  int bcnt [NI];
  bit rerr [NI];

  // Present a request for one cycle, then observe both responders until each has pulsed ready.
  task automatic issue(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [34:0] o;
    rd = r; wr = w; addr = a; wdata = d;
    for (int i = 0; i < NI; i++) begin
      lat[i] = -1; bcnt[i] = 0; rerr[i] = 1'b0;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        o = outs(i);
        if (o[34]) bcnt[i]++;
        if (o[33] && lat[i] < 0) begin
          lat[i]  = k;
          rerr[i] = o[32];
        end
      end
      tick();
      if (k == 0) begin rd = 1'b0; wr = 1'b0; end
      if (lat[0] >= 0 && lat[1] >= 0) break;
    end
    for (int i = 0; i < NI; i++) chk($sformatf("ready_seen%0d", i), {31'd0, lat[i] >= 0}, 32'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int nrdy;

  initial begin
    rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = '0; wdata = '0;
    repeat (2) tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy0", {31'd0, bus0.o_busy}, 32'd0);
    chk("rst_busy1", {31'd0, bus1.o_busy}, 32'd0);
    chk("rst_ready0", {31'd0, bus0.o_ready}, 32'd0);
    chk("rst_err0", {31'd0, bus0.o_err}, 32'd0);
    chk("rst_data0", bus0.o_data, 32'd0);
    tick();
    rst = 1'b0; rd = 1'b0;
    tick();

    for (int w = 0; w < 256; w++) issue(1'b0, 1'b1, 32'(w * 4), $urandom);

    issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    chk("wr_latency_w2", lat[0], 32'd3);
    chk("wr_busy_w2", bcnt[0], 32'd3);
    chk("wr_latency_w0", lat[1], 32'd1);
    chk("wr_busy_w0", bcnt[1], 32'd1);
    chk("wr_err_w2", {31'd0, rerr[0]}, 32'd0);
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    chk("rd_0x10_w2", bus0.o_data, 32'hDEADBEEF);
    chk("rd_0x10_w0", bus1.o_data, 32'hDEADBEEF);

    issue(1'b0, 1'b1, 32'h0, 32'h1);
    issue(1'b1, 1'b0, 32'h0, 32'h0);
    chk("rd_0x0_latency_w0", lat[1], 32'd1);
    chk("rd_0x0_w0", bus1.o_data, 32'h1);

    issue(1'b1, 1'b1, 32'h8, 32'h7);
    chk("both_err_w2", {31'd0, rerr[0]}, 32'd1);
    chk("both_err_w0", {31'd0, rerr[1]}, 32'd1);
    chk("both_data_kept", bus0.o_data, 32'h1);
    issue(1'b1, 1'b0, 32'h8, 32'h0);
    chk("rd_word2", bus0.o_data, 32'h7);

    issue(1'b0, 1'b1, 32'h13, 32'hAA);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misal_err", {31'd0, rerr[0]}, 32'd1);
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    chk("word4_after_misal", bus0.o_data, 32'hDEADBEEF);
`else
    chk("misal_err", {31'd0, rerr[0]}, 32'd0);
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    chk("word4_after_misal", bus0.o_data, 32'hAA);
`endif

    issue(1'b0, 1'b1, 32'h400, 32'h99);
    issue(1'b1, 1'b0, 32'h0, 32'h0);
    chk("wrap_w2", bus0.o_data, 32'h99);
    chk("wrap_w0", bus1.o_data, 32'h99);

    issue(1'b0, 1'b1, 32'h20, 32'h11);
    rd = 1'b0; wr = 1'b1; addr = 32'h20; wdata = 32'h55;
    tick();
    wr = 1'b0; rst = 1'b1; nrdy = 0;
    @(negedge clk);
    if (bus0.o_ready) nrdy++;
    tick();
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus0.o_ready) nrdy++;
      tick();
    end
    chk("rst_abort_no_ready", nrdy, 32'd0);
    issue(1'b1, 1'b0, 32'h20, 32'h0);
    chk("rst_abort_w2", bus0.o_data, 32'h11);
    chk("rst_abort_w0", bus1.o_data, 32'h11);

    for (int it = 0; it < 400; it++) begin
      int unsigned v, h;
      v     = $urandom_range(0, 7);
      rd    = (v <= 2) || (v == 6);
      wr    = (v >= 3) && (v <= 6);
      addr  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      wdata = $urandom;
      rst   = ($urandom_range(0, 49) == 0);
      h     = $urandom_range(1, 3);
      repeat (h) tick();
      rst = 1'b0;
    end
    rd = 1'b0; wr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!pend[0] && !pend[1]) break;
      tick();
    end
    chk("drain", {31'd0, pend[0] || pend[1]}, 32'd0);
    tick();

    for (int w = 0; w < 16; w++) issue(1'b1, 1'b0, 32'(w * 4), 32'h0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8: log2 of memory depth in 32-bit words (256 words).
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each access completes; legal range 0..15.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_MemRead  input  1  read request from the datapath memory stage.
REQ-006 i_MemWrite  input  1  write request from the datapath memory stage.
REQ-007 i_address  input  32  byte address; word index = i_address[ADDR_W+1:2], upper bits ignored (wrap).
REQ-008 i_data  input  32  write data.
REQ-009 o_data  output  32  read data, registered.
REQ-010 o_ready  output  1  one-cycle completion pulse.
REQ-011 o_busy  output  1  stall request to the pipeline hazard logic.
REQ-012 o_err  output  1  error pulse, coincident with o_ready.

Function
REQ-013 The block SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE with i_MemRead|i_MemWrite high, the block SHALL latch address, data and type, and go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-015 In WAIT, a 4-bit counter SHALL count WAIT_CYCLES cycles, then transition to RESP.
REQ-016 In RESP, the block SHALL perform the latched access, pulse o_ready for exactly one cycle and return to IDLE.
REQ-017 Latency: request accepted at edge N; o_ready high during cycle N+1+WAIT_CYCLES.
REQ-018 A write SHALL commit to memory at the RESP edge; read data SHALL appear on o_data in the RESP cycle and hold until the next read completes.
REQ-019 o_busy SHALL be combinational: high when (IDLE and request present) or WAIT; low in RESP and when idle without request.
REQ-020 Both i_MemRead and i_MemWrite high: write SHALL take priority, o_err SHALL pulse with o_ready, o_data unchanged.
REQ-021 Request inputs changing during WAIT/RESP SHALL be ignored; latched values are used.
REQ-022 Back-to-back: a request present in the cycle after RESP SHALL be accepted immediately; a read of a just-written word SHALL return the new value.
REQ-023 Address wrap: byte address 4*2^ADDR_W SHALL access word 0.

Reset
REQ-024 With i_rst high at an edge: state IDLE, counter 0, o_data 0, o_ready 0, o_err 0.
REQ-025 o_busy SHALL be 0 while i_rst is high.
REQ-026 Reset during WAIT SHALL abort the access with no memory write and no o_ready pulse.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DMEM_ALIGN_CHECK_EN: when defined, a request with i_address[1:0]!=0 SHALL complete normally in timing, perform no write, leave o_data unchanged and pulse o_err with o_ready.
REQ-029 Without DMEM_ALIGN_CHECK_EN, i_address[1:0] SHALL be ignored and only REQ-020 sets o_err.

Verification
REQ-030 Write 0xDEADBEEF to 0x10, WAIT_CYCLES=2 -> o_busy high 3 cycles, o_ready at cycle 3 after accept; read 0x10 -> o_data=0xDEADBEEF.
REQ-031 WAIT_CYCLES=0, write 0x1 to 0x0 then read 0x0 back-to-back -> each completes in 1 cycle, read returns 0x00000001.
REQ-032 i_rst asserted in WAIT of write 0x55 to 0x20 -> no o_ready; subsequent read of 0x20 returns prior contents.
REQ-033 Read and write both high, address 0x8, data 0x7 -> o_err=1 with o_ready, word 2 = 0x7.
REQ-034 Macro defined, write 0xAA to 0x13 -> o_err=1, word 4 unchanged; macro undefined -> word 4 = 0xAA, o_err=0.
REQ-035 ADDR_W=8, write 0x99 to 0x400, read 0x0 -> 0x00000099.
